// File: rtl/pattern_dir_decoder.sv
// Recovers step direction from a 5-state ring pattern code, tracks lock
// acquisition, net step position and error statistics.
module pattern_dir_decoder #(
    parameter int unsigned LOCK_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] q_in,
    input  logic       q_valid,
    input  logic       err_clr,
    output logic       w_out,
    output logic       w_valid,
    output logic       locked,
    output logic       err,
    output logic [7:0] step_cnt,
    output logic [7:0] err_cnt
);

    localparam int unsigned CODE_W = 3;
    localparam int unsigned RUN_W  = 4;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  prev_q, prev_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               w_out_q, w_out_d;
    logic               w_valid_q, w_valid_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               code_ok;
    logic               is_fwd;
    logic               is_bwd;
    logic               err_event;
    logic [CODE_W-1:0]  prev_plus;
    logic [CODE_W-1:0]  prev_minus;
    logic [RUN_W-1:0]   run_inc;

    // State and output registers; reset discards any stored sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            run_q      <= '0;
            w_out_q    <= 1'b0;
            w_valid_q  <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            step_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            run_q      <= run_d;
            w_out_q    <= w_out_d;
            w_valid_q  <= w_valid_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            step_cnt_q <= step_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Next-state, direction decode, step tracking and error accounting.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        run_d      = run_q;
        w_out_d    = w_out_q;
        w_valid_d  = 1'b0;
        step_cnt_d = step_cnt_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;
        err_event  = 1'b0;

        code_ok    = (q_in <= CODE_W'(4));
        prev_plus  = (prev_q == CODE_W'(4)) ? CODE_W'(0) : prev_q + CODE_W'(1);
        prev_minus = (prev_q == CODE_W'(0)) ? CODE_W'(4) : prev_q - CODE_W'(1);
        is_fwd     = (q_in == prev_plus);
        is_bwd     = (q_in == prev_minus);
        run_inc    = run_q + RUN_W'(1);

        if (q_valid) begin
            case (state_q)
                IDLE: begin
                    if (code_ok) begin
                        prev_d  = q_in;
                        run_d   = '0;
                        state_d = ACQ;
                    end else begin
                        err_event = 1'b1;
                    end
                end
                ACQ, LOCK: begin
                    if (!code_ok) begin
                        err_event = 1'b1;
                        run_d     = '0;
                        state_d   = IDLE;
                    end else if (is_fwd || is_bwd) begin
                        prev_d    = q_in;
                        w_valid_d = 1'b1;
                        w_out_d   = is_fwd;
                        if (state_q == LOCK) begin
                            step_cnt_d = is_fwd ? step_cnt_q + CNT_W'(1)
                                                : step_cnt_q - CNT_W'(1);
                        end else begin
                            run_d = run_inc;
                            if (run_inc == RUN_W'(LOCK_LEN)) begin
                                state_d    = LOCK;
                                step_cnt_d = '0;
                            end
                        end
                    end else begin
                        err_event = 1'b1;
                        prev_d    = q_in;
                        run_d     = '0;
                        state_d   = ACQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end

        // A clear request wins over the old count but not over a fresh error.
        if (err_clr) begin
            err_d     = err_event;
            err_cnt_d = err_event ? CNT_W'(1) : CNT_W'(0);
        end else if (err_event) begin
            err_d = 1'b1;
            if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end

        locked_d = (state_d == LOCK);
    end

    assign w_out    = w_out_q;
    assign w_valid  = w_valid_q;
    assign locked   = locked_q;
    assign err      = err_q;
    assign step_cnt = step_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_pattern_dir_decoder.sv
// Directed bench for pattern_dir_decoder with hand-computed expectations.
module tb_pattern_dir_decoder;

    logic       clk;
    logic       rst;
    logic [2:0] q_in;
    logic       q_valid;
    logic       err_clr;
    logic       w_out;
    logic       w_valid;
    logic       locked;
    logic       err;
    logic [7:0] step_cnt;
    logic [7:0] err_cnt;

    int checks;
    int errors;
    int pulses;

    pattern_dir_decoder #(.LOCK_LEN(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .q_in     (q_in),
        .q_valid  (q_valid),
        .err_clr  (err_clr),
        .w_out    (w_out),
        .w_valid  (w_valid),
        .locked   (locked),
        .err      (err),
        .step_cnt (step_cnt),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Present one input cycle, then settle just after the capturing edge.
    task automatic drive(input logic v, input logic [2:0] q, input logic clr);
        @(negedge clk);
        q_valid = v;
        q_in    = q;
        err_clr = clr;
        @(posedge clk);
        #1;
        q_valid = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic samp(input logic [2:0] q);
        drive(1'b1, q, 1'b0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        pulses  = 0;
        rst     = 1'b1;
        q_in    = '0;
        q_valid = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_w_out", 32'(w_out), 0);
        chk("rst_w_valid", 32'(w_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_step", 32'(step_cnt), 0);
        chk("rst_errcnt", 32'(err_cnt), 0);

        // Forward acquisition 0,1,2,3,4,0
        samp(3'd0);
        chk("acq_first_wv", 32'(w_valid), 0);
        samp(3'd1);
        pulses += int'(w_valid && w_out);
        chk("acq1_locked", 32'(locked), 0);
        samp(3'd2);
        pulses += int'(w_valid && w_out);
        chk("acq2_locked", 32'(locked), 1);
        chk("acq2_step", 32'(step_cnt), 0);
        for (int i = 3; i <= 5; i++) begin
            samp(3'(i % 5));
            pulses += int'(w_valid && w_out);
        end
        chk("fwd_pulses", 32'(pulses), 5);
        chk("fwd_step", 32'(step_cnt), 3);

        // Hold with q_valid low
        drive(1'b0, 3'd3, 1'b0);
        chk("hold_wv", 32'(w_valid), 0);
        chk("hold_wout", 32'(w_out), 1);
        chk("hold_step", 32'(step_cnt), 3);

        // Reach q=2 then go backward 1,0,4
        samp(3'd1);
        samp(3'd2);
        chk("to2_step", 32'(step_cnt), 5);
        samp(3'd1);
        chk("bwd1_wv", 32'(w_valid), 1);
        chk("bwd1_wout", 32'(w_out), 0);
        samp(3'd0);
        chk("bwd2_wout", 32'(w_out), 0);
        samp(3'd4);
        chk("bwd3_wv", 32'(w_valid), 1);
        chk("bwd3_wout", 32'(w_out), 0);
        chk("bwd_step", 32'(step_cnt), 2);
        chk("bwd_locked", 32'(locked), 1);

        // Illegal transition 1->3 in LOCK, then relock
        samp(3'd0);
        samp(3'd1);
        chk("pre_ill_step", 32'(step_cnt), 4);
        samp(3'd3);
        chk("ill_wv", 32'(w_valid), 0);
        chk("ill_err", 32'(err), 1);
        chk("ill_errcnt", 32'(err_cnt), 1);
        chk("ill_locked", 32'(locked), 0);
        samp(3'd4);
        chk("rel1_wv", 32'(w_valid), 1);
        chk("rel1_locked", 32'(locked), 0);
        samp(3'd0);
        chk("rel2_locked", 32'(locked), 1);
        chk("rel2_step", 32'(step_cnt), 0);

        // Lone clear
        drive(1'b0, 3'd0, 1'b1);
        chk("clr_err", 32'(err), 0);
        chk("clr_errcnt", 32'(err_cnt), 0);

        // Illegal code 6 in LOCK -> IDLE, reacquire 2,3,4
        samp(3'd6);
        chk("code6_err", 32'(err), 1);
        chk("code6_locked", 32'(locked), 0);
        samp(3'd2);
        chk("idle2_wv", 32'(w_valid), 0);
        samp(3'd3);
        chk("idle3_wv", 32'(w_valid), 1);
        chk("idle3_locked", 32'(locked), 0);
        samp(3'd4);
        chk("idle4_locked", 32'(locked), 1);

        // 4->2 illegal (count 2), then repeated 2 with clear
        samp(3'd2);
        chk("pre_clr_errcnt", 32'(err_cnt), 2);
        drive(1'b1, 3'd2, 1'b1);
        chk("clr_ev_err", 32'(err), 1);
        chk("clr_ev_errcnt", 32'(err_cnt), 1);
        drive(1'b0, 3'd0, 1'b1);
        chk("clr2_err", 32'(err), 0);
        chk("clr2_errcnt", 32'(err_cnt), 0);

        // Relock from prev=2 and run 130 forward steps
        samp(3'd3);
        samp(3'd4);
        chk("wrap_pre_locked", 32'(locked), 1);
        chk("wrap_pre_step", 32'(step_cnt), 0);
        for (int i = 1; i <= 130; i++) begin
            samp(3'((4 + i) % 5));
            if (i == 128) chk("wrap_128", 32'(step_cnt), 32'h80);
        end
        chk("wrap_130", 32'(step_cnt), 32'h82);
        // prev is (4+130)%5 = 4; backward to 3 from 0x82
        samp(3'd3);
        chk("wrap_bwd", 32'(step_cnt), 32'h81);
        chk("wrap_bwd_wout", 32'(w_out), 0);

        // 300 illegal codes saturate the counter
        for (int i = 0; i < 300; i++) begin
            samp(3'd7);
            if (i == 253) chk("sat_254", 32'(err_cnt), 254);
        end
        chk("sat_255", 32'(err_cnt), 255);
        chk("sat_err", 32'(err), 1);
        chk("sat_wout_hold", 32'(w_out), 0);

        // Reset wins over q_valid and err_clr and drops the stored sample
        samp(3'd0);
        @(negedge clk);
        rst     = 1'b1;
        q_valid = 1'b1;
        q_in    = 3'd1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        q_valid = 1'b0;
        err_clr = 1'b0;
        chk("rstp_errcnt", 32'(err_cnt), 0);
        chk("rstp_locked", 32'(locked), 0);
        samp(3'd1);
        chk("rstp_nowv", 32'(w_valid), 0);
        samp(3'd2);
        chk("rstp_wv", 32'(w_valid), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_dir_decoder.md
PATTERN_DIR_DECODER -- requirements
Module: pattern_dir_decoder

Interface
REQ-001 Parameter LOCK_LEN, default 2: number of consecutive legal transitions required to enter LOCK (range 1..15).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 q_in  input  3  observed 5-state ring pattern code; legal values 0..4.
REQ-005 q_valid  input  1  q_in sampled only on cycles where q_valid=1.
REQ-006 err_clr  input  1  single-cycle request to clear err and err_cnt.
REQ-007 w_out  output  1  recovered direction: 1 = forward step, 0 = backward step.
REQ-008 w_valid  output  1  one-cycle pulse; w_out is meaningful on this cycle.
REQ-009 locked  output  1  high while the FSM is in LOCK.
REQ-010 err  output  1  sticky error flag.
REQ-011 step_cnt  output  8  signed net step position; two's complement, wraps.
REQ-012 err_cnt  output  8  count of detected errors; saturates at 255.

Function
REQ-013 Forward transition SHALL be prev->(prev+1) mod 5, i.e. 0->1->2->3->4->0; backward SHALL be prev->(prev-1) mod 5, i.e. 0->4->3->2->1->0.
REQ-014 Any other pair with both codes legal, including a repeated code (prev==new), SHALL be an illegal transition.
REQ-015 A sampled q_in of 5, 6 or 7 SHALL be an illegal code.
REQ-016 FSM states SHALL be IDLE (no stored sample), ACQ (stored sample, counting), LOCK.
REQ-017 IDLE: legal code -> store as prev, run=0, go to ACQ; illegal code -> error, stay IDLE.
REQ-018 ACQ: legal transition -> prev=new, run+1; when run reaches LOCK_LEN go to LOCK.
REQ-019 LOCK: legal transition -> prev=new, stay LOCK.
REQ-020 ACQ or LOCK: illegal transition -> error, prev=new, run=0, next state ACQ.
REQ-021 ACQ or LOCK: illegal code -> error, prev invalidated, run=0, next state IDLE.
REQ-022 Every legal transition in ACQ or LOCK SHALL assert w_valid for exactly one cycle, with w_out=direction, on the clock edge after the q_valid sample (latency 1).
REQ-023 step_cnt SHALL increment (forward) or decrement (backward) by 1 only on legal transitions taken while already in LOCK; 127+1 wraps to -128 and -128-1 wraps to 127.
REQ-024 Entry into LOCK from ACQ SHALL clear step_cnt to 0 on the same edge.
REQ-025 Each error event SHALL set err=1 and increment err_cnt by 1 unless it is already 255.
REQ-026 err_clr SHALL clear err and err_cnt on the next edge; if an error event occurs on the same cycle, err=1 and err_cnt=1.
REQ-027 With q_valid=0, state, prev, run, step_cnt and w_out SHALL hold, w_valid=0, and err_clr SHALL still act.
REQ-028 w_out SHALL hold its last value between w_valid pulses.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 On rst=1 at an edge: state=IDLE, prev invalid, run=0, w_out=0, w_valid=0, locked=0, err=0, step_cnt=0, err_cnt=0.
REQ-031 rst SHALL take priority over q_valid and err_clr; mid-stream reset discards the stored sample.

Verification
REQ-032 LOCK_LEN=2; rst, then q_valid with q_in 0,1,2,3,4,0 -> w_valid pulses 5 times with w_out=1, locked=1 after sample 2, final step_cnt=+3.
REQ-033 In LOCK at q=2, apply q_in 1,0,4 -> w_out=0 pulses ×3, step_cnt decreases by 3, locked stays 1.
REQ-034 In LOCK at q=1, apply q_in 3 -> no w_valid, err=1, err_cnt=1, locked=0 (ACQ); then q_in 4,0 -> relock, step_cnt=0.
REQ-035 In LOCK, apply q_in 6 -> err=1, state IDLE, locked=0; next q_in 2 produces no w_valid; 3 then 4 -> locked=1.
REQ-036 err_clr asserted on the same cycle as a repeated code (q_in 2 after 2) -> err=1, err_cnt=1; err_clr alone next cycle -> err=0, err_cnt=0.
REQ-037 Locked forward run of 130 steps from step_cnt=0 -> step_cnt wraps to -126; 300 illegal codes -> err_cnt=255.
